bmem_arbiter: RTL and testbench

Shares the single 64-bit banked-memory port (bmem) between the instruction-cache and data-cache line-fill/write-back interfaces. Grants one cache-line transaction at a time with two-way round-robin arbitration, then drives the burst itself: one read command plus four collected beats, or four serialized write beats. Sits between the two caches' dfp ports and the top-level bmem pins, and replaces per-cache serializer/deserializer glue.

---
 rtl/bmem_arb_pkg.sv | 30 +++
 rtl/bmem_rr_pick.sv | 21 ++
 rtl/bmem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_bmem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmem_arb_pkg.sv
// Shared sizing and types for the instruction/data cache arbiter in front of
// the single banked-memory port.
package bmem_arb_pkg;

    localparam int LINE_W           = 256;
    localparam int BEAT_W           = 64;
    localparam int BEATS            = LINE_W / BEAT_W;
    localparam int LINE_OFFSET_BITS = 5;

    localparam logic [31:0] LINE_MASK = ~((32'd1 << LINE_OFFSET_BITS) - 32'd1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_BURST,
        RESP
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

    // Cache-line aligned version of a byte address.
    function automatic logic [31:0] line_addr(input logic [31:0] addr);
        return addr & LINE_MASK;
    endfunction

endpackage

// File: rtl/bmem_rr_pick.sv
// Two-way round-robin picker: bit 0 is the icache, bit 1 the dcache.
// On a tie the requester that was not granted last time wins.
module bmem_rr_pick
    import bmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == REQ_D) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/bmem_arbiter.sv
// Shares the 64-bit bmem port between icache and dcache line transactions,
// running one four-beat read or write burst at a time on behalf of the winner.
module bmem_arbiter
    import bmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic [31:0]       i_dfp_addr,
    input  logic              i_dfp_read,
    output logic [LINE_W-1:0] i_dfp_rdata,
    output logic              i_dfp_resp,

    input  logic [31:0]       d_dfp_addr,
    input  logic              d_dfp_read,
    input  logic              d_dfp_write,
    input  logic [LINE_W-1:0] d_dfp_wdata,
    output logic [LINE_W-1:0] d_dfp_rdata,
    output logic              d_dfp_resp,

    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [31:0]       bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    arb_state_t        state;
    arb_state_t        state_next;
    requester_t        owner;
    requester_t        last_grant;
    logic [1:0]        beat;
    logic [31:0]       addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] line_buf;
    logic [LINE_W-1:0] i_rdata_q;
    logic [LINE_W-1:0] d_rdata_q;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic              beat_hit;
    logic              last_beat;

    assign req       = {d_dfp_read | d_dfp_write, i_dfp_read};
    assign beat_hit  = bmem_rvalid && (bmem_raddr == addr_q);
    assign last_beat = (beat == 2'd3);

    bmem_rr_pick u_pick (
        .req   (req),
        .last  (last_grant),
        .grant (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A dcache grant with write asserted becomes a write burst even if read is also high.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (grant[1]) begin
                    state_next = d_dfp_write ? WR_BURST : RD_REQ;
                end else if (grant[0]) begin
                    state_next = RD_REQ;
                end
            end
            RD_REQ: begin
                if (bmem_ready) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (beat_hit && last_beat) begin
                    state_next = RESP;
                end
            end
            WR_BURST: begin
                if (bmem_ready && last_beat) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The owner's rdata register is loaded together with the final beat so the
    // completed line is already visible during the response cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= REQ_I;
            last_grant <= REQ_D;
            beat       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            line_buf   <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        owner      <= grant[1] ? REQ_D : REQ_I;
                        last_grant <= grant[1] ? REQ_D : REQ_I;
                        addr_q     <= line_addr(grant[1] ? d_dfp_addr : i_dfp_addr);
                        wdata_q    <= d_dfp_wdata;
                        beat       <= '0;
                    end
                end
                RD_REQ: begin
                    beat <= '0;
                end
                RD_WAIT: begin
                    if (beat_hit) begin
                        line_buf[int'(beat)*BEAT_W +: BEAT_W] <= bmem_rdata;
                        beat <= beat + 2'd1;
                        if (last_beat) begin
                            if (owner == REQ_D) begin
                                d_rdata_q <= {bmem_rdata, line_buf[LINE_W-BEAT_W-1:0]};
                            end else begin
                                i_rdata_q <= {bmem_rdata, line_buf[LINE_W-BEAT_W-1:0]};
                            end
                        end
                    end
                end
                WR_BURST: begin
                    if (bmem_ready) begin
                        beat <= beat + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Everything on the bmem side is decoded from registered state only.
    always_comb begin
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        i_dfp_resp = 1'b0;
        d_dfp_resp = 1'b0;
        case (state)
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = addr_q;
            end
            WR_BURST: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q;
                bmem_wdata = wdata_q[int'(beat)*BEAT_W +: BEAT_W];
            end
            RESP: begin
                i_dfp_resp = (owner == REQ_I);
                d_dfp_resp = (owner == REQ_D);
            end
            default: ;
        endcase
    end

    assign i_dfp_rdata = i_rdata_q;
    assign d_dfp_rdata = d_rdata_q;

endmodule

// File: tb/tb_bmem_arbiter.sv
// Self-checking bench for bmem_arbiter: a transaction-level model of the
// arbiter plus a bench-side memory and two requesters driven by $urandom.
module tb_bmem_arbiter;

    logic         clk = 1'b0;
    logic         rst;

    logic [31:0]  i_dfp_addr;
    logic         i_dfp_read;
    logic [255:0] i_dfp_rdata;
    logic         i_dfp_resp;
    logic [31:0]  d_dfp_addr;
    logic         d_dfp_read;
    logic         d_dfp_write;
    logic [255:0] d_dfp_wdata;
    logic [255:0] d_dfp_rdata;
    logic         d_dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    bmem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .i_dfp_addr  (i_dfp_addr),
        .i_dfp_read  (i_dfp_read),
        .i_dfp_rdata (i_dfp_rdata),
        .i_dfp_resp  (i_dfp_resp),
        .d_dfp_addr  (d_dfp_addr),
        .d_dfp_read  (d_dfp_read),
        .d_dfp_write (d_dfp_write),
        .d_dfp_wdata (d_dfp_wdata),
        .d_dfp_rdata (d_dfp_rdata),
        .d_dfp_resp  (d_dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Transaction-level model: busy/owner/op plus progress counts.
    bit           m_busy, m_resp, m_write, m_cmd, m_owner, m_last;
    int           m_beats;
    logic [31:0]  m_addr;
    logic [255:0] m_wline, m_line, m_irdata, m_drdata;

    // Requester bookkeeping for the randomized traffic.
    bit i_pend, i_drop, d_pend, d_drop;

    task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_resp  = 0;
        m_write = 0;
        m_cmd   = 0;
        m_owner = 0;
        m_last  = 1;
        m_beats = 0;
        m_addr  = '0;
        m_wline = '0;
        m_line  = '0;
        m_irdata = '0;
        m_drdata = '0;
    endtask

    // Advance the model by one clock using the inputs currently being driven.
    task automatic model_update();
        bit iv, dv, pick_d;
        if (m_resp) begin
            m_resp = 0;
            m_busy = 0;
        end else if (!m_busy) begin
            iv = i_dfp_read;
            dv = d_dfp_read | d_dfp_write;
            if (iv || dv) begin
                pick_d  = dv && (!iv || m_last == 0);
                m_owner = pick_d;
                m_last  = pick_d;
                m_busy  = 1;
                m_addr  = (pick_d ? d_dfp_addr : i_dfp_addr) & 32'hFFFF_FFE0;
                m_write = pick_d && d_dfp_write;
                m_wline = d_dfp_wdata;
                m_beats = 0;
                m_cmd   = 0;
            end
        end else if (!m_write) begin
            if (!m_cmd) begin
                if (bmem_ready) m_cmd = 1;
            end else if (bmem_rvalid && bmem_raddr == m_addr) begin
                m_line[m_beats*64 +: 64] = bmem_rdata;
                m_beats++;
                if (m_beats == 4) begin
                    m_resp = 1;
                    if (m_owner) m_drdata = m_line;
                    else m_irdata = m_line;
                end
            end
        end else if (bmem_ready) begin
            m_beats++;
            if (m_beats == 4) m_resp = 1;
        end
    endtask

    task automatic checkOutput();
        bit e_rd, e_wr;
        e_rd = m_busy && !m_resp && !m_write && !m_cmd;
        e_wr = m_busy && !m_resp && m_write;
        cmp("bmem_read", bmem_read, e_rd);
        cmp("bmem_write", bmem_write, e_wr);
        cmp("bmem_addr", bmem_addr, (e_rd || e_wr) ? m_addr : 32'h0);
        cmp("bmem_wdata", bmem_wdata, e_wr ? m_wline[m_beats*64 +: 64] : 64'h0);
        cmp("i_dfp_resp", i_dfp_resp, m_resp && !m_owner);
        cmp("d_dfp_resp", d_dfp_resp, m_resp && m_owner);
        cmp("i_dfp_rdata", i_dfp_rdata, m_irdata);
        cmp("d_dfp_rdata", d_dfp_rdata, m_drdata);
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    // Asynchronous reset raised mid-cycle; bmem outputs must drop at once.
    task automatic doReset();
        #1 rst = 1'b1;
        #1;
        cmp("rst_bmem_write_async", bmem_write, 1'b0);
        model_reset();
        i_drop = 0;
        d_drop = 0;
        checkOutput();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput();
    endtask

    // One cycle of randomized requesters and memory, then advance.
    task automatic applyStimulus(input int req_pct, input int wr_pct, input int rdy_pct, input int stray_pct);
        bit w, rd_phase;
        if (i_drop) begin
            i_drop = 0;
            i_pend = 0;
            i_dfp_read = 0;
        end else if (!i_pend && $urandom_range(99) < req_pct) begin
            i_pend = 1;
            i_dfp_read = 1;
            i_dfp_addr = $urandom;
        end
        if (m_resp && !m_owner && i_pend) i_drop = 1;

        if (d_drop) begin
            d_drop = 0;
            d_pend = 0;
            d_dfp_read = 0;
            d_dfp_write = 0;
        end else if (!d_pend && $urandom_range(99) < req_pct) begin
            d_pend = 1;
            w = ($urandom_range(99) < wr_pct);
            d_dfp_write = w;
            d_dfp_read = w ? ($urandom_range(3) == 0) : 1'b1;
            d_dfp_addr = $urandom;
            d_dfp_wdata = rand_line();
        end
        if (m_resp && m_owner && d_pend) d_drop = 1;

        bmem_ready = ($urandom_range(99) < rdy_pct);
        rd_phase = m_busy && !m_resp && !m_write && m_cmd;
        if (rd_phase) begin
            bmem_rvalid = ($urandom_range(99) < 70);
            bmem_raddr = ($urandom_range(99) < stray_pct) ? (m_addr ^ 32'h0000_2000) : m_addr;
        end else begin
            bmem_rvalid = ($urandom_range(99) < stray_pct);
            bmem_raddr = m_addr;
        end
        bmem_rdata = {$urandom, $urandom};
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0]  rd_addr [5];
        logic [63:0]  rd_data [5];
        logic [63:0]  wr_exp [6];
        logic [63:0]  wr_seen [6];
        bit           wr_rdy [6];
        int           order[$];
        bit           got;

        rst = 1'b1;
        i_dfp_addr = '0; i_dfp_read = 0;
        d_dfp_addr = '0; d_dfp_read = 0; d_dfp_write = 0; d_dfp_wdata = '0;
        bmem_ready = 0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 0;
        i_pend = 0; i_drop = 0; d_pend = 0; d_drop = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput();
        cmp("reset_bmem_read", bmem_read, 1'b0);
        cmp("reset_i_rdata", i_dfp_rdata, 256'h0);

        // Icache read of 0x1004 with a stray beat for 0x3000 in the middle.
        $display("[TB] icache read with stray beat");
        i_dfp_read = 1; i_dfp_addr = 32'h0000_1004; bmem_ready = 0;
        tick();
        cmp("rd_bmem_read", bmem_read, 1'b1);
        cmp("rd_bmem_addr", bmem_addr, 32'h0000_1000);
        tick();
        bmem_ready = 1;
        tick();
        bmem_ready = 0;
        rd_addr = '{32'h0000_1000, 32'h0000_3000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000};
        rd_data = '{64'h1111_1111_1111_1111, 64'hDEAD_DEAD_DEAD_DEAD, 64'h2222_2222_2222_2222,
                    64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        for (int k = 0; k < 5; k++) begin
            bmem_rvalid = 1; bmem_raddr = rd_addr[k]; bmem_rdata = rd_data[k];
            tick();
        end
        bmem_rvalid = 0;
        cmp("rd_i_resp", i_dfp_resp, 1'b1);
        cmp("rd_d_resp", d_dfp_resp, 1'b0);
        cmp("rd_i_rdata", i_dfp_rdata,
            256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        tick();
        cmp("rd_i_resp_one_cycle", i_dfp_resp, 1'b0);
        i_dfp_read = 0;
        tick();

        // Dcache write with ready low for two cycles on the second beat.
        $display("[TB] dcache write with stall");
        wr_exp = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 64'hBBBB_BBBB_BBBB_BBBB,
                   64'hBBBB_BBBB_BBBB_BBBB, 64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
        wr_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        d_dfp_write = 1; d_dfp_addr = 32'h0000_2000;
        d_dfp_wdata = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                       64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        bmem_ready = 1;
        tick();
        for (int c = 0; c < 6; c++) begin
            wr_seen[c] = bmem_write ? bmem_wdata : 64'h0;
            bmem_ready = wr_rdy[c];
            tick();
        end
        for (int c = 0; c < 6; c++) cmp($sformatf("wr_beat%0d", c), wr_seen[c], wr_exp[c]);
        cmp("wr_resp_cycle7", d_dfp_resp, 1'b1);
        tick();
        d_dfp_write = 0;
        tick();

        // Read and write both asserted: write burst wins.
        $display("[TB] dcache read+write together");
        d_dfp_read = 1; d_dfp_write = 1; d_dfp_addr = 32'h0000_4010; d_dfp_wdata = rand_line();
        bmem_ready = 1;
        tick();
        cmp("rw_bmem_write", bmem_write, 1'b1);
        cmp("rw_bmem_read", bmem_read, 1'b0);
        repeat (4) tick();
        cmp("rw_d_resp", d_dfp_resp, 1'b1);
        tick();
        d_dfp_read = 0; d_dfp_write = 0;
        tick();

        // Reset during the second write beat, then a normal icache read.
        $display("[TB] reset mid-write");
        d_dfp_write = 1; d_dfp_addr = 32'h0000_5000; d_dfp_wdata = rand_line(); bmem_ready = 1;
        tick();
        tick();
        doReset();
        d_dfp_write = 0;
        i_dfp_read = 1; i_dfp_addr = 32'h0000_6000; i_pend = 1;
        got = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            applyStimulus(0, 0, 75, 10);
            if (i_dfp_resp) got = 1;
        end
        cmp("rst_recover_read_resp", got, 1'b1);

        // Ties from reset must alternate I, D, I, D.
        $display("[TB] round-robin ties");
        for (int n = 0; n < 3; n++) applyStimulus(0, 0, 75, 10);
        doReset();
        i_pend = 0; d_pend = 0; i_dfp_read = 0; d_dfp_read = 0; d_dfp_write = 0;
        for (int n = 0; n < 400 && order.size() < 4; n++) begin
            applyStimulus(100, 0, 75, 10);
            if (i_dfp_resp) order.push_back(0);
            if (d_dfp_resp) order.push_back(1);
        end
        cmp("tie_count", order.size(), 4);
        for (int k = 0; k < order.size() && k < 4; k++)
            cmp($sformatf("tie_order%0d", k), order[k], k % 2);

        // Randomized mixed traffic with occasional resets.
        $display("[TB] random traffic");
        for (int n = 0; n < 4000; n++) begin
            if (n == 2000 || $urandom_range(399) == 0) doReset();
            applyStimulus(40, 50, 75, 10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
